// File: rtl/ahfp_fixed_2_float_pipe.sv
// Signed fixed-point (IN_W bits, FRAC_W fraction bits) to IEEE-754 single, 3-stage pipeline.
// Define AHFP_ROUND_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module ahfp_fixed_2_float_pipe #(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data
);
    localparam int PW = $clog2(IN_W);
`ifdef AHFP_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic [2:0] vld_q, vld_d;
    logic       stall;

    logic            s1_sign_q, s1_sign_d;
    logic [IN_W-1:0] s1_mag_q, s1_mag_d;
    logic            s2_sign_q;
    logic [PW-1:0]   s2_p_q, s2_p_d;
    logic [IN_W-1:0] s2_norm_q, s2_norm_d;
    logic [31:0]     s3_q, s3_d;

    // A stall freezes every stage at once, so nothing moves or drops.
    assign stall     = vld_q[2] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[2];
    assign out_data  = rst ? 32'h0 : s3_q;
    assign vld_d     = {vld_q[1:0], in_valid};

    // S1: sign and unsigned magnitude; the most negative value stays representable.
    always_comb begin
        s1_sign_d = in_data[IN_W-1];
        s1_mag_d  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
    end

    // S2: leading-one position and left-normalise so the leading one sits at the MSB.
    always_comb begin
        s2_p_d = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag_q[i]) s2_p_d = PW'(i);
        end
        s2_norm_d = s1_mag_q << (PW'(IN_W - 1) - s2_p_d);
    end

    // S3: round, adjust exponent, pack.
    logic                 s3_nz;
    logic [IN_W+22:0]     s3_ext;
    logic [22:0]          s3_man;
    logic                 s3_guard, s3_sticky, s3_rnd;
    logic [23:0]          s3_man_r;
    logic [7:0]           s3_exp;

    always_comb begin
        s3_nz     = s2_norm_q[IN_W-1];
        s3_ext    = {s2_norm_q[IN_W-2:0], 24'h0};
        s3_man    = s3_ext[IN_W+22 -: 23];
        s3_guard  = s3_ext[IN_W-1];
        s3_sticky = |s3_ext[IN_W-2:0];
        s3_rnd    = RNE & s3_guard & (s3_sticky | s3_man[0]);
        // On carry-out the low 23 bits are already zero; only the exponent moves.
        s3_man_r  = {1'b0, s3_man} + 24'(s3_rnd);
        s3_exp    = 8'd127 + 8'(s2_p_q) - 8'(FRAC_W) + 8'(s3_man_r[23]);
        s3_d      = s3_nz ? {s2_sign_q, s3_exp, s3_man_r[22:0]} : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            s3_q  <= '0;
        end else if (!stall) begin
            vld_q <= vld_d;
            if (vld_q[1]) s3_q <= s3_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
            end
            if (vld_q[0]) begin
                s2_sign_q <= s1_sign_q;
                s2_p_q    <= s2_p_d;
                s2_norm_q <= s2_norm_d;
            end
        end
    end
endmodule

// File: tb/tb_ahfp_fixed_2_float_pipe.sv
// Scoreboard bench for ahfp_fixed_2_float_pipe at IN_W=32, FRAC_W=16 (either rounding build).
module tb_ahfp_fixed_2_float_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    ahfp_fixed_2_float_pipe #(.IN_W(32), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one item and wait (bounded) for acceptance; optionally record its expected result.
    task automatic send(input logic [31:0] d, input logic [31:0] e, input bit track);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            if (acc && track) sb.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", {31'h0, in_ready}, 32'h1);
    endtask

    // Output monitor: handshake, hold-during-stall and scoreboard ordering.
    initial begin
        logic [31:0] held;
        bit held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready_vs_stall", {31'h0, in_ready}, {31'h0, !(out_valid && !out_ready)});
                if (held_v) begin
                    chk("hold_valid", {31'h0, out_valid}, 32'h1);
                    chk("hold_data", out_data, held);
                end
                held_v = out_valid && !out_ready;
                held   = out_data;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("spurious_out_valid", {31'h0, out_valid}, 32'h0);
                    else                chk("out_data", out_data, sb.pop_front());
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        int n;
        logic [31:0] bp_in [5];
        logic [31:0] bp_exp[5];
        bp_in  = '{32'h0000_8000, 32'h0003_0000, 32'hFFFE_8000, 32'h0064_0000, 32'h7FFF_0000};
        bp_exp = '{32'h3F00_0000, 32'h4040_0000, 32'hBFC0_0000, 32'h42C8_0000, 32'h46FF_FE00};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("post_rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;

        // Isolated item: result appears on the third cycle after acceptance.
        send(32'h0001_0000, 32'h3F80_0000, 1'b1);
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("latency", n, 32'd3);
        @(posedge clk); #1;

        send(32'hFFFF_0000, 32'hBF80_0000, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1);
        send(32'h8000_0000, 32'hC700_0000, 1'b1);
        send(32'h0000_0001, 32'h3780_0000, 1'b1);
        send(32'h0100_0001, 32'h4380_0000, 1'b1);
`ifdef AHFP_ROUND_RNE_EN
        send(32'h7FFF_FFFF, 32'h4700_0000, 1'b1);
        send(32'h0100_0003, 32'h4380_0002, 1'b1);
`else
        send(32'h7FFF_FFFF, 32'h46FF_FFFF, 1'b1);
        send(32'h0100_0003, 32'h4380_0001, 1'b1);
`endif

        // Back-to-back stream with a 4-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 5; i++) send(bp_in[i], bp_exp[i], 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_backpressure", sb.size(), 32'd0);
        @(posedge clk); #1;

        // Reset with three items in flight: none of them may ever come out.
        out_ready = 1'b0;
        send(32'h0005_0000, 32'h40A0_0000, 1'b0);
        send(32'h0006_0000, 32'h40C0_0000, 1'b0);
        send(32'h0007_0000, 32'h40E0_0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("after_rst_out_data", out_data, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        send(32'h000A_0000, 32'h4120_0000, 1'b1);
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_final", sb.size(), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
